// File: rtl/fir_pkg.sv
// Shared constants for the FIR output chain: sample widths, the default
// Q-format shift and the 16-bit saturation bounds.
package fir_pkg;

  localparam int FIR_OUT_W     = 32;
  localparam int SAMPLE_W      = 16;
  localparam int DEFAULT_SHIFT = 15;

  localparam int SAT_MAX = (1 << (SAMPLE_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (SAMPLE_W - 1));

endpackage

// File: rtl/fir_out_requant_if.sv
// Sample-stream bundle around the requantizer: a push-only input (the FIR
// cannot stall) and a valid/ready output.
interface fir_out_requant_if import fir_pkg::*; #(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = SAMPLE_W
);

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

endinterface

// File: rtl/fir_out_requant_sync_fifo.sv
// Synchronous FIFO with a registered head. A written entry becomes visible
// one cycle after the write (no bypass). Pointers carry one extra bit so a
// full buffer is told apart from an empty one.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count;
  logic [PW-1:0] avail;
  logic [W-1:0]  dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          do_pop;
  logic          do_push;

  // Pointer arithmetic and the next head value; the head only looks at
  // entries stored before this edge, so a same-cycle write never bypasses.
  always_comb begin
    count   = wptr_q - rptr_q;
    full    = (count == PW'(DEPTH));
    do_pop  = pop & vld_q;
    do_push = push & (~full | do_pop);
    rptr_d  = rptr_q + PW'(do_pop);
    wptr_d  = wptr_q + PW'(do_push);
    avail   = wptr_q - rptr_d;
    vld_d   = (avail != '0);
    dout_d  = vld_d ? mem_q[rptr_d[AW-1:0]] : dout_q;
  end

  // Pointers and the registered head; clear behaves exactly like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

  // Storage array; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign dout  = dout_q;
  assign empty = ~vld_q;

endmodule

// File: rtl/fir_out_requant.sv
// Requantizer after the pipelined FIR: decimate, round half-up, shift,
// saturate to OUT_W and queue the result behind a valid/ready port.
// Kept samples that find the queue full are dropped and counted.
module fir_out_requant import fir_pkg::*; #(
  parameter int IN_W       = FIR_OUT_W,
  parameter int OUT_W      = SAMPLE_W,
  parameter int SHIFT      = DEFAULT_SHIFT,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  fir_out_requant_if.slave     bus,
  output logic                 sat_flag,
  output logic                 ovf_flag,
  output logic [7:0]           drop_cnt
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RW   = IN_W + 1;

  localparam logic signed [RW-1:0] SAT_MAX_R = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN_R = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Add half an LSB of the output grid, then arithmetic shift; the extra
  // bit keeps the add from wrapping, so exact halves go toward +inf.
  function automatic logic signed [RW-1:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] half;
    ext             = {x[IN_W-1], x};
    half            = '0;
    half[SHIFT-1]   = 1'b1;
    return (ext + half) >>> SHIFT;
  endfunction

  function automatic logic is_clamped(input logic signed [RW-1:0] r);
    return (r > SAT_MAX_R) || (r < SAT_MIN_R);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_clamp(input logic signed [RW-1:0] r);
    if (r > SAT_MAX_R)      return SAT_MAX_R[OUT_W-1:0];
    else if (r < SAT_MIN_R) return SAT_MIN_R[OUT_W-1:0];
    else                    return r[OUT_W-1:0];
  endfunction

  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    keep;
  logic                    vld_p1_q;
  logic signed [RW-1:0]    r_p1_q;
  logic                    vld_p2_q;
  logic signed [OUT_W-1:0] s_p2_q;
  logic                    sat_q, ovf_q;
  logic [7:0]              drop_q;
  logic                    fifo_full, fifo_empty;
  logic [OUT_W-1:0]        fifo_dout;
  logic                    pop;
  logic                    drop;

  // Decimation phase: one sample in DECIM is kept, starting with the first.
  always_comb begin
    keep    = bus.in_valid & (phase_q == '0);
    phase_d = phase_q;
    if (bus.in_valid) begin
      if (phase_q == PH_W'(DECIM - 1)) phase_d = '0;
      else                             phase_d = phase_q + PH_W'(1);
    end
    pop  = bus.out_valid & bus.out_ready;
    drop = vld_p2_q & fifo_full & ~pop;
  end

  // Control state: phase, stage valids and sticky status; flush wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else if (flush) begin
      phase_q  <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      phase_q  <= phase_d;
      vld_p1_q <= keep;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q && is_clamped(r_p1_q)) sat_q <= 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Datapath registers, qualified by the stage valids rather than reset.
  always_ff @(posedge clk) begin
    // stage 1: round and shift
    if (keep) r_p1_q <= round_shift(bus.in_data);
    // stage 2: clamp to the output range
    if (vld_p1_q) s_p2_q <= sat_clamp(r_p1_q);
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (flush),
    .push  (vld_p2_q),
    .pop   (bus.out_ready),
    .din   (s_p2_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_dout;
  assign sat_flag      = sat_q;
  assign ovf_flag      = ovf_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: one DECIM=1 and one DECIM=4 instance share the
// same stimulus; a queue-based model predicts outputs, flags and drops.
module tb_fir_out_requant;
  import fir_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, flush, in_valid, out_ready;
  logic signed [31:0] in_data;
  logic               sat0, ovf0, sat1, ovf1;
  logic [7:0]         drop0, drop1;

  fir_out_requant_if bus0 ();
  fir_out_requant_if bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  fir_out_requant #(.DECIM(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus0),
    .sat_flag(sat0), .ovf_flag(ovf0), .drop_cnt(drop0));

  fir_out_requant #(.DECIM(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus1),
    .sat_flag(sat1), .ovf_flag(ovf1), .drop_cnt(drop1));

  // ---------------- reference model ----------------
  typedef struct { int d; int val; bit sat; int kedge; } pend_t;
  typedef struct { int d; int val; int wedge; } ent_t;

  pend_t pend_q[$];
  ent_t  fq[$];
  int    m_cnt[2];
  bit    m_sat[2], m_ovf[2], m_vld[2];
  int    m_drop[2];
  int    edge_n;
  int    n_chk, n_fail;
  int    cap0[$], cap1[$];
  int    first0;

  function automatic int decim_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Floor((x + 2^14) / 2^15), then clamp to 16-bit range.
  function automatic int requant(input logic signed [31:0] x, output bit s);
    longint v, q;
    v = longint'(x) + 16384;
    if (v >= 0) q = v / 32768;
    else        q = -((-v + 32767) / 32768);
    s = (q > 32767) || (q < -32768);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic int fhead(int d);
    for (int i = 0; i < fq.size(); i++) if (fq[i].d == d) return i;
    return -1;
  endfunction

  function automatic int fsize(int d);
    int n = 0;
    for (int i = 0; i < fq.size(); i++) if (fq[i].d == d) n++;
    return n;
  endfunction

  task automatic m_clear(int d);
    int i;
    i = 0;
    while (i < pend_q.size()) if (pend_q[i].d == d) pend_q.delete(i); else i++;
    i = 0;
    while (i < fq.size()) if (fq[i].d == d) fq.delete(i); else i++;
    m_cnt[d] = 0; m_sat[d] = 0; m_ovf[d] = 0; m_vld[d] = 0; m_drop[d] = 0;
  endtask

  task automatic model_edge(int e);
    bit pop, s;
    int i, h, v;
    for (int d = 0; d < 2; d++) begin
      if (flush) begin m_clear(d); continue; end
      pop = m_vld[d] && out_ready;
      foreach (pend_q[k]) if (pend_q[k].d == d && pend_q[k].kedge == e - 1 && pend_q[k].sat) m_sat[d] = 1;
      if (pop) fq.delete(fhead(d));
      i = 0;
      while (i < pend_q.size()) begin
        if (pend_q[i].d == d && pend_q[i].kedge == e - 2) begin
          if (fsize(d) >= DEPTH) begin
            m_ovf[d] = 1;
            if (m_drop[d] < 255) m_drop[d]++;
          end else fq.push_back('{d, pend_q[i].val, e});
          pend_q.delete(i);
        end else i++;
      end
      if (in_valid) begin
        if (m_cnt[d] % decim_of(d) == 0) begin
          v = requant(in_data, s);
          pend_q.push_back('{d, v, s, e});
        end
        m_cnt[d]++;
      end
      h = fhead(d);
      m_vld[d] = (h >= 0) && (fq[h].wedge <= e - 1);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("vld0", bus0.out_valid, m_vld[0]);
    if (m_vld[0]) chk("dat0", bus0.out_data, fq[fhead(0)].val);
    chk("sat0", sat0, m_sat[0]);
    chk("ovf0", ovf0, m_ovf[0]);
    chk("drop0", drop0, m_drop[0]);
    chk("vld1", bus1.out_valid, m_vld[1]);
    if (m_vld[1]) chk("dat1", bus1.out_data, fq[fhead(1)].val);
    chk("sat1", sat1, m_sat[1]);
    chk("ovf1", ovf1, m_ovf[1]);
    chk("drop1", drop1, m_drop[1]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld0"}, bus0.out_valid, 0);
    chk({tag, "_dat0"}, bus0.out_data, 0);
    chk({tag, "_sat0"}, sat0, 0);
    chk({tag, "_ovf0"}, ovf0, 0);
    chk({tag, "_drop0"}, drop0, 0);
    chk({tag, "_vld1"}, bus1.out_valid, 0);
    chk({tag, "_dat1"}, bus1.out_data, 0);
    chk({tag, "_sat1"}, sat1, 0);
    chk({tag, "_ovf1"}, ovf1, 0);
    chk({tag, "_drop1"}, drop1, 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    if (bus0.out_valid && out_ready) cap0.push_back(int'(bus0.out_data));
    if (bus1.out_valid && out_ready) cap1.push_back(int'(bus1.out_data));
    @(posedge clk);
    edge_n++;
    model_edge(edge_n);
    #1;
    cmp_all();
    if (bus0.out_valid && first0 < 0) first0 = edge_n;
  endtask

  task automatic drive(input bit v, input logic signed [31:0] x);
    in_valid = v;
    in_data  = x;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'sd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    in_valid = 1'b0;
    step();
    chk_zero("flush");
    flush = 1'b0;
  endtask

  // Called right after step(): reset pulse lands mid-cycle.
  task automatic areset();
    #2 reset_n = 1'b0;
    #1;
    m_clear(0);
    m_clear(1);
    chk_zero("areset");
    #1 reset_n = 1'b1;
  endtask

  function automatic logic signed [31:0] rnd_data();
    int t;
    case ($urandom_range(0, 3))
      0: t = int'($urandom);
      1: t = int'($urandom_range(0, 2097151)) - 1048576;
      2: t = (int'($urandom_range(0, 200)) - 100) * 32768 + 16384 + int'($urandom_range(0, 2)) - 1;
      default: begin
        t = 1073709056 + int'($urandom_range(0, 65535)) - 32768;
        if ($urandom_range(0, 1) == 1) t = -t;
      end
    endcase
    return t;
  endfunction

  task automatic fill_for_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'sh7FFFFFFF);
    for (int k = 2; k <= 20; k++) drive(1'b1, 32'(k <<< 15));
    idle(4);
    chk("fill_sat1", sat1, 1);
    chk("fill_vld1", bus1.out_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp1[4];
    int e0;
    n_chk = 0; n_fail = 0; edge_n = 0; first0 = -1;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_clear(0); m_clear(1);
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Test 1: rounding, DECIM=1, 3-cycle latency
    do_flush();
    out_ready = 1'b1;
    cap0.delete(); first0 = -1; e0 = edge_n + 1;
    drive(1'b1, 32'sd32768);
    drive(1'b1, 32'sd16384);
    drive(1'b1, -32'sd16384);
    drive(1'b1, -32'sd16385);
    idle(6);
    exp1 = '{1, 1, 0, -1};
    chk("t1_n", cap0.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_dat", (i < cap0.size()) ? cap0[i] : 99999, exp1[i]);
    chk("t1_lat", first0 - e0, 3);

    // Test 2: saturation both ways, sticky flag
    do_flush();
    cap0.delete();
    drive(1'b1, 32'sh7FFFFFFF);
    drive(1'b1, 32'sh80000000);
    chk("t2_sat_early", sat0, 1);
    idle(6);
    chk("t2_n", cap0.size(), 2);
    chk("t2_max", (cap0.size() > 0) ? cap0[0] : 0, 32767);
    chk("t2_min", (cap0.size() > 1) ? cap0[1] : 0, -32768);
    chk("t2_sat", sat0, 1);

    // Test 3: DECIM=4, continuous then gapped
    do_flush();
    cap1.delete();
    for (int k = 1; k <= 8; k++) drive(1'b1, 32'(k <<< 15));
    idle(8);
    chk("t3_n", cap1.size(), 2);
    chk("t3_a", (cap1.size() > 0) ? cap1[0] : 0, 1);
    chk("t3_b", (cap1.size() > 1) ? cap1[1] : 0, 5);
    do_flush();
    cap1.delete();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 32'(k <<< 15));
      drive(1'b0, 32'sd0);
    end
    idle(8);
    chk("t3g_n", cap1.size(), 2);
    chk("t3g_a", (cap1.size() > 0) ? cap1[0] : 0, 1);
    chk("t3g_b", (cap1.size() > 1) ? cap1[1] : 0, 5);

    // Test 4: overflow with stalled consumer, then drain
    do_flush();
    out_ready = 1'b0;
    for (int k = 1; k <= 40; k++) drive(1'b1, 32'(k <<< 15));
    idle(4);
    chk("t4_drop", drop1, 2);
    chk("t4_ovf", ovf1, 1);
    cap1.delete();
    out_ready = 1'b1;
    idle(12);
    chk("t4_n", cap1.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4_dat", (i < cap1.size()) ? cap1[i] : 0, 1 + 4 * i);
    chk("t4_empty", bus1.out_valid, 0);

    // Test 5: full FIFO, write and pop on the same edge
    do_flush();
    out_ready = 1'b0;
    for (int k = 1; k <= 32; k++) drive(1'b1, 32'(k <<< 15));
    idle(4);
    drive(1'b1, 32'(33 <<< 15));
    drive(1'b0, 32'sd0);
    out_ready = 1'b1;
    drive(1'b0, 32'sd0);
    out_ready = 1'b0;
    idle(2);
    chk("t5_drop", drop1, 0);
    chk("t5_ovf", ovf1, 0);
    cap1.delete();
    out_ready = 1'b1;
    idle(12);
    chk("t5_n", cap1.size(), 8);
    chk("t5_first", (cap1.size() > 0) ? cap1[0] : 0, 5);
    chk("t5_last", (cap1.size() > 7) ? cap1[7] : 0, 33);

    // Test 6: async reset and flush while holding data
    do_flush();
    fill_for_reset();
    areset();
    cap1.delete();
    out_ready = 1'b1;
    drive(1'b1, 32'(3 <<< 15));
    idle(6);
    chk("t6r_n", cap1.size(), 1);
    chk("t6r_v", (cap1.size() > 0) ? cap1[0] : 0, 3);
    do_flush();
    fill_for_reset();
    do_flush();
    cap1.delete();
    out_ready = 1'b1;
    drive(1'b1, 32'(3 <<< 15));
    idle(6);
    chk("t6f_n", cap1.size(), 1);
    chk("t6f_v", (cap1.size() > 0) ? cap1[0] : 0, 3);

    // Randomized traffic against the model
    do_flush();
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, rnd_data());
      flush     = 1'b0;
      if ($urandom_range(0, 399) == 0) areset();
    end
    out_ready = 1'b1;
    idle(16);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
